// File: rtl/rv_imm_pkg.sv
// Shared immediate-format encodings and range helpers for the RV32 immediate encoder.
package rv_imm_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsel_e;

  localparam int XLEN  = 32;

  // Highest immediate bit each format can represent; everything above must match it.
  localparam int MSB_I = 11;
  localparam int MSB_S = 11;
  localparam int MSB_B = 12;
  localparam int MSB_J = 20;

  function automatic logic fits(input logic [XLEN-1:0] v, input int msb);
    logic [XLEN-1:0] hi;
    hi = XLEN'($signed(v) >>> msb);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational scatter of a signed immediate into I/S/B/J instruction bit positions,
// plus range and alignment checks for the selected format.
module imm_pack
  import rv_imm_pkg::*;
(
  input  logic [1:0]      immsel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] base,
  output logic [XLEN-1:0] inst,
  output logic            range_err,
  output logic            align_err
);

  always_comb begin
    inst      = base;
    range_err = 1'b0;
    case (immsel)
      IMM_I: begin
        inst[31:20] = imm[11:0];
        range_err   = !fits(imm, MSB_I);
      end
      IMM_S: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
        range_err   = !fits(imm, MSB_S);
      end
      IMM_B: begin
        inst[31]    = imm[12];
        inst[30:25] = imm[10:5];
        inst[11:8]  = imm[4:1];
        inst[7]     = imm[11];
        range_err   = !fits(imm, MSB_B);
      end
      IMM_J: begin
        inst[31]    = imm[20];
        inst[30:21] = imm[10:1];
        inst[20]    = imm[11];
        inst[19:12] = imm[19:12];
        range_err   = !fits(imm, MSB_J);
      end
      default: inst = base;
    endcase
    // Branch and jump offsets are halfword-aligned; bit 0 has no encoding slot.
    align_err = immsel[1] & imm[0];
  end

endmodule

// File: rtl/imm_enc.sv
// Two-stage valid/ready immediate encoder: S1 captures the request, S2 holds the packed
// instruction and flags; saturating counters track transferred outputs.
module imm_enc
  import rv_imm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       immsel,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [WIDTH-1:0] base_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] inst_out,
  output logic             range_err,
  output logic             align_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic             s1_valid;
  logic [1:0]       s1_sel;
  logic [WIDTH-1:0] s1_imm;
  logic [WIDTH-1:0] s1_base;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             xfer;
  logic [WIDTH-1:0] pack_inst;
  logic             pack_range;
  logic             pack_align;

  assign s2_adv    = !s2_valid | out_ready;
  assign s1_adv    = !s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign xfer      = s2_valid & out_ready;

  imm_pack u_pack (
    .immsel    (s1_sel),
    .imm       (s1_imm),
    .base      (s1_base),
    .inst      (pack_inst),
    .range_err (pack_range),
    .align_err (pack_align)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sel   <= 2'b00;
      s1_imm   <= '0;
      s1_base  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sel  <= immsel;
        s1_imm  <= imm_in;
        s1_base <= base_inst;
      end
    end
  end

  // Output registers only move when S2 advances, so a stalled output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      inst_out  <= '0;
      range_err <= 1'b0;
      align_err <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        inst_out  <= pack_inst;
        range_err <= pack_range;
        align_err <= pack_align;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (cnt_clr) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (xfer) begin
      if (range_err | align_err) begin
        if (!(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
      end else begin
        if (!(&ok_cnt)) ok_cnt <= ok_cnt + CNT_W'(1);
      end
    end
  end

endmodule
